// File: rtl/riscv_next_pkg.sv
// Shared types and constants for the next-address predictor blocks.
//   ras_op_t        : stack operation decoded at ID, encoded as {call, ret}
//   RAS_LINK_OFFSET : byte distance from a call PC to its return address
package riscv_next_pkg;

  // Encoding equals {i_id_call, i_id_ret}, so decode is a plain cast.
  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSH    = 2'b10,
    RAS_POPPUSH = 2'b11
  } ras_op_t;

  localparam int RAS_LINK_OFFSET = 4;

endpackage

// File: rtl/riscv_next_ras_stack.sv
// Return-address stack storage with top-of-stack/count arithmetic and a
// multi-port restore path used when speculative operations are squashed.
//
// Ports:
//   clk, nreset     clock, asynchronous active-low reset
//   upd             state may change this cycle
//   op              operation to apply (ignored while restore is high)
//   push_data       return address written by PUSH / POPPUSH
//   restore         squash: apply restore writes instead of op
//   rst_we/idx/data restore writes, index 0 youngest, highest index oldest
//   rst_ptr_valid   rst_tos / rst_count hold the pointer state to restore
//   tos, count      current top-of-stack index and number of valid entries
//   top_data        entry at tos (the prediction source)
//   wslot_data      pre-op content of the slot op would write
//   overflow        registered pulse: a push evicted the oldest entry
module riscv_next_ras_stack
  import riscv_next_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int RAS_DEPTH   = 8,
  parameter int NUM_RESTORE = 1
) (
  input  logic                                           clk,
  input  logic                                           nreset,
  input  logic                                           upd,
  input  logic [1:0]                                     op,
  input  logic [ADDR_WIDTH-1:0]                          push_data,
  input  logic                                           restore,
  input  logic [NUM_RESTORE-1:0]                         rst_we,
  input  logic [NUM_RESTORE-1:0][$clog2(RAS_DEPTH)-1:0]  rst_idx,
  input  logic [NUM_RESTORE-1:0][ADDR_WIDTH-1:0]         rst_data,
  input  logic                                           rst_ptr_valid,
  input  logic [$clog2(RAS_DEPTH)-1:0]                   rst_tos,
  input  logic [$clog2(RAS_DEPTH+1)-1:0]                 rst_count,
  output logic [$clog2(RAS_DEPTH)-1:0]                   tos,
  output logic [$clog2(RAS_DEPTH+1)-1:0]                 count,
  output logic [ADDR_WIDTH-1:0]                          top_data,
  output logic [ADDR_WIDTH-1:0]                          wslot_data,
  output logic                                           overflow
);

  localparam int TW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem_q   [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_nxt [RAS_DEPTH];
  logic [TW-1:0]         tos_q, tos_nxt, tos_inc, tos_dec;
  logic [CW-1:0]         count_q, count_nxt;
  logic                  overflow_q, overflow_nxt;
  logic                  is_full, is_empty;

  // Depth is a power of two, so natural TW-bit wrap gives the modulo.
  assign tos_inc  = tos_q + TW'(1);
  assign tos_dec  = tos_q - TW'(1);
  assign is_full  = (count_q == CW'(RAS_DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    mem_nxt      = mem_q;
    tos_nxt      = tos_q;
    count_nxt    = count_q;
    overflow_nxt = 1'b0;
    if (upd) begin
      if (restore) begin
        // Ascending index = youngest first; the oldest record writes last
        // and therefore wins when several records saved the same slot.
        for (int i = 0; i < NUM_RESTORE; i++) begin
          if (rst_we[i]) mem_nxt[rst_idx[i]] = rst_data[i];
        end
        if (rst_ptr_valid) begin
          tos_nxt   = rst_tos;
          count_nxt = rst_count;
        end
      end else begin
        case (op)
          RAS_PUSH: begin
            tos_nxt          = tos_inc;
            mem_nxt[tos_inc] = push_data;
            // At full the new top lands on the oldest entry's slot.
            if (is_full) overflow_nxt = 1'b1;
            else         count_nxt    = count_q + CW'(1);
          end
          RAS_POP: begin
            if (!is_empty) begin
              tos_nxt   = tos_dec;
              count_nxt = count_q - CW'(1);
            end
          end
          RAS_POPPUSH: begin
            mem_nxt[tos_q] = push_data;
            if (is_empty) count_nxt = CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      tos_q      <= TW'(RAS_DEPTH - 1);
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_nxt;
      tos_q      <= tos_nxt;
      count_q    <= count_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  assign tos        = tos_q;
  assign count      = count_q;
  assign top_data   = mem_q[tos_q];
  assign wslot_data = (op == RAS_PUSH) ? mem_q[tos_inc] : mem_q[tos_q];
  assign overflow   = overflow_q;

endmodule

// File: rtl/riscv_next_ras_predictor.sv
// Speculative return-address stack for the next-address predictor.
// Calls push and returns predict at ID; every stack operation travels as an
// undo record until it reaches the resolution stage, so a redirect from
// there rebuilds the exact stack seen before the squashed instructions.
//
// Ports:
//   clk, nreset     clock, asynchronous active-low reset
//   enable          predictor enable (contents kept while low)
//   i_stall         pipeline stall, freezes all state
//   i_id_valid      ID holds a non-flushed instruction
//   i_id_call       ID instruction is a call
//   i_id_ret        ID instruction is a return
//   i_id_pc         PC of the ID instruction
//   i_recover       resolution stage redirect, younger work squashed
//   o_inject        predicted-return injection request (combinational)
//   o_inject_addr   predicted return address, 0 when not injecting
//   o_count         valid entries; o_empty / o_full derived from it
//   o_overflow      one-cycle pulse after a push evicted the oldest entry
//
// Handshake: o_inject is a request with no back-pressure; IF-inject muxing
// takes it in the same cycle it is asserted, stalled or not.
module riscv_next_ras_predictor
  import riscv_next_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int RAS_DEPTH    = 8,
  parameter int TRACK_STAGES = 1
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           enable,
  input  logic                           i_stall,
  input  logic                           i_id_valid,
  input  logic                           i_id_call,
  input  logic                           i_id_ret,
  input  logic [ADDR_WIDTH-1:0]          i_id_pc,
  input  logic                           i_recover,
  output logic                           o_inject,
  output logic [ADDR_WIDTH-1:0]          o_inject_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_count,
  output logic                           o_empty,
  output logic                           o_full,
  output logic                           o_overflow
);

  localparam int TW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  // Records that can be squashed: rec[0 .. TRACK_STAGES-2]. Keep at least
  // one restore port so the vectors stay legal when nothing is squashable.
  localparam int NR = (TRACK_STAGES > 1) ? TRACK_STAGES - 1 : 1;

  typedef struct packed {
    logic                  valid;
    ras_op_t               op;
    logic [TW-1:0]         tos;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] data;
  } ras_rec_t;

  logic                          upd;
  ras_op_t                       id_op;
  logic [ADDR_WIDTH-1:0]         push_data;
  logic [TW-1:0]                 tos;
  logic [CW-1:0]                 count;
  logic [ADDR_WIDTH-1:0]         top_data;
  logic [ADDR_WIDTH-1:0]         wslot_data;
  logic                          overflow;
  ras_rec_t                      rec_new;
  ras_rec_t                      rec_q [TRACK_STAGES];
  logic [NR-1:0]                 rst_we;
  logic [NR-1:0][TW-1:0]         rst_idx;
  logic [NR-1:0][ADDR_WIDTH-1:0] rst_data;
  logic                          rst_ptr_valid;
  logic [TW-1:0]                 rst_tos;
  logic [CW-1:0]                 rst_count;

  assign upd       = enable && !i_stall;
  assign push_data = i_id_pc + ADDR_WIDTH'(RAS_LINK_OFFSET);

  always_comb begin
    id_op = RAS_NONE;
    if (i_id_valid) id_op = ras_op_t'({i_id_call, i_id_ret});
  end

  // Undo record for this cycle's op: pointer state and the slot contents
  // it is about to overwrite.
  always_comb begin
    rec_new       = '0;
    rec_new.valid = (id_op != RAS_NONE);
    rec_new.op    = id_op;
    rec_new.tos   = tos;
    rec_new.count = count;
    rec_new.data  = wslot_data;
  end

  // Restore selection over the squashable records. The pointer state comes
  // from the oldest valid one (last hit in the ascending scan).
  always_comb begin
    rst_we        = '0;
    rst_idx       = '0;
    rst_data      = '0;
    rst_ptr_valid = 1'b0;
    rst_tos       = '0;
    rst_count     = '0;
    for (int i = 0; i < TRACK_STAGES - 1; i++) begin
      if (rec_q[i].valid) begin
        if (rec_q[i].op == RAS_PUSH || rec_q[i].op == RAS_POPPUSH) begin
          rst_we[i]   = 1'b1;
          rst_idx[i]  = (rec_q[i].op == RAS_PUSH) ? rec_q[i].tos + TW'(1)
                                                  : rec_q[i].tos;
          rst_data[i] = rec_q[i].data;
        end
        rst_ptr_valid = 1'b1;
        rst_tos       = rec_q[i].tos;
        rst_count     = rec_q[i].count;
      end
    end
  end

  // On recover every younger record is squashed and the resolving one
  // retires, so the whole pipeline empties.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < TRACK_STAGES; i++) rec_q[i] <= '0;
    end else if (upd) begin
      if (i_recover) begin
        for (int i = 0; i < TRACK_STAGES; i++) rec_q[i] <= '0;
      end else begin
        rec_q[0] <= rec_new;
        for (int i = 1; i < TRACK_STAGES; i++) rec_q[i] <= rec_q[i-1];
      end
    end
  end

  riscv_next_ras_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RAS_DEPTH   (RAS_DEPTH),
    .NUM_RESTORE (NR)
  ) u_stack (
    .clk           (clk),
    .nreset        (nreset),
    .upd           (upd),
    .op            (id_op),
    .push_data     (push_data),
    .restore       (i_recover),
    .rst_we        (rst_we),
    .rst_idx       (rst_idx),
    .rst_data      (rst_data),
    .rst_ptr_valid (rst_ptr_valid),
    .rst_tos       (rst_tos),
    .rst_count     (rst_count),
    .tos           (tos),
    .count         (count),
    .top_data      (top_data),
    .wslot_data    (wslot_data),
    .overflow      (overflow)
  );

  assign o_inject      = enable && i_id_valid && i_id_ret && (count != '0);
  assign o_inject_addr = o_inject ? top_data : '0;
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_full        = (count == CW'(RAS_DEPTH));
  assign o_overflow    = overflow;

endmodule
